// File: rtl/instr_pkg.sv
// ----------------------------------------------------------------------------
// instr_pkg
// Shared definitions for the 8-bit instruction-memory format, used by both the
// loader (writer side) and the decoder side.
//   - field widths and bit positions of the packed instruction byte
//   - INSTR_W: width of one packed instruction
//   - loader_state_e: loader FSM state encoding
//   - pack_instr(): fields -> byte
// Byte layout: [7:5] aux, [4] rs, [3] rt, [2:0] opcode.
// ----------------------------------------------------------------------------
package instr_pkg;

    localparam int INSTR_W    = 8;
    localparam int OPCODE_W   = 3;
    localparam int AUX_W      = 3;

    localparam int OPCODE_LSB = 0;
    localparam int RT_BIT     = 3;
    localparam int RS_BIT     = 4;
    localparam int AUX_LSB    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    // Places each field at its fixed bit position; every bit of the byte is
    // covered by exactly one field, so the zero default is always overwritten.
    function automatic logic [INSTR_W-1:0] pack_instr(
        input logic [OPCODE_W-1:0] opcode,
        input logic                rt,
        input logic                rs,
        input logic [AUX_W-1:0]    aux
    );
        logic [INSTR_W-1:0] b;
        b = '0;
        b[OPCODE_LSB +: OPCODE_W] = opcode;
        b[RT_BIT]                 = rt;
        b[RS_BIT]                 = rs;
        b[AUX_LSB +: AUX_W]       = aux;
        return b;
    endfunction

endpackage

// File: rtl/instr_packer.sv
// ----------------------------------------------------------------------------
// instr_packer
// Purely combinational packer: decoded instruction fields -> one byte.
// Ports:
//   opcode [2:0]  in   opcode field
//   rt            in   rt register-select bit
//   rs            in   rs register-select bit
//   aux    [2:0]  in   aux field
//   packed_byte [7:0] out  {aux, rs, rt, opcode}
// ----------------------------------------------------------------------------
module instr_packer
    import instr_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                rt,
    input  logic                rs,
    input  logic [AUX_W-1:0]    aux,
    output logic [INSTR_W-1:0]  packed_byte
);

    always_comb begin
        packed_byte = pack_instr(opcode, rt, rs, aux);
    end

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
// Writer side of the 8-bit instruction-memory format. Accepts decoded field
// tuples over a valid/ready stream, packs each into one byte and issues one
// write strobe per accepted tuple, exactly one cycle after the accept, at
// sequential addresses starting from BASE_ADDR.
//
// Parameters:
//   ADDR_W     instruction memory address width
//   DEPTH      number of writable bytes (must be <= 2**ADDR_W)
//   BASE_ADDR  first address written after each start
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse, begins a load session (ignored in LOAD)
//   in_valid   in   field tuple present
//   in_ready   out  loader accepts a tuple this cycle (high in LOAD)
//   in_opcode  in   opcode field [2:0]
//   in_rt      in   rt bit
//   in_rs      in   rs bit
//   in_aux     in   aux field [2:0]
//   in_last    in   final instruction of the program
//   mem_we     out  single-cycle write strobe
//   mem_addr   out  write address [ADDR_W-1:0]
//   mem_wdata  out  packed instruction byte [7:0]
//   busy       out  high in LOAD
//   done       out  high in DONE
//   overflow   out  session ended because memory filled before in_last
//   count      out  instructions written in current/last session [ADDR_W:0]
//   checksum   out  running XOR of written bytes [7:0]
//                   (only when INSTR_MEM_LOADER_CHECKSUM_EN is defined)
//
// Optional feature macro: INSTR_MEM_LOADER_CHECKSUM_EN
// ----------------------------------------------------------------------------
module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int               ADDR_W    = 8,
    parameter int               DEPTH     = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] in_opcode,
    input  logic                in_rt,
    input  logic                in_rs,
    input  logic [AUX_W-1:0]    in_aux,
    input  logic                in_last,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [INSTR_W-1:0]  mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                overflow,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    output logic [INSTR_W-1:0]  checksum,
`endif
    output logic [ADDR_W:0]     count
);

    // Address of the last writable byte; an accept at this address without
    // in_last ends the session as an overflow.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE_ADDR + DEPTH - 1);

    loader_state_e        state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [INSTR_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 in_ready_q, in_ready_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0]   checksum_q, checksum_d;
`endif

    logic [INSTR_W-1:0]   packed_byte;
    logic                 accept;

    instr_packer u_packer (
        .opcode      (in_opcode),
        .rt          (in_rt),
        .rs          (in_rs),
        .aux         (in_aux),
        .packed_byte (packed_byte)
    );

    // in_ready_q is high exactly when the state is LOAD, so this is the
    // valid/ready handshake.
    assign accept = in_ready_q & in_valid;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    ptr_d      = BASE_ADDR;
                    count_d    = '0;
                    overflow_d = 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = packed_byte;
                    ptr_d       = ptr_q + 1'b1;
                    count_d     = count_q + 1'b1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    checksum_d  = checksum_q ^ packed_byte;
`endif
                    // in_last wins over the full-memory check, so a program
                    // that exactly fills memory is not flagged as overflow.
                    if (in_last) begin
                        state_d = DONE;
                    end else if (ptr_q == LAST_ADDR) begin
                        state_d    = DONE;
                        overflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d     = (state_d == LOAD);
        done_d     = (state_d == DONE);
        in_ready_d = (state_d == LOAD);
    end

    // Single state register for the FSM, pointer, write port and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= BASE_ADDR;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign count     = count_q;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    assign checksum  = checksum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
// Self-checking bench for instr_mem_loader, instantiated with DEPTH=4 and
// BASE_ADDR=0 so the full-memory boundary is reachable in a few cycles.
// A table of per-cycle vectors (inputs and the outputs expected after the
// following clock edge) covers the main flows; hand-written sequences cover
// reset values and reset in the middle of a session.
// Checksum comparisons are included when INSTR_MEM_LOADER_CHECKSUM_EN is set.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_opcode;
    logic              in_rt;
    logic              in_rs;
    logic [2:0]        in_aux;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   count;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    int checks_total;
    int checks_passed;

    instr_mem_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rt     (in_rt),
        .in_rs     (in_rs),
        .in_aux    (in_aux),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       valid;
        logic [2:0] op;
        logic       rt;
        logic       rs;
        logic [2:0] aux;
        logic       last;
        logic       e_we;
        logic [7:0] e_addr;
        logic [7:0] e_data;
        logic       e_busy;
        logic       e_done;
        logic       e_ready;
        logic       e_ovf;
        logic [8:0] e_count;
        logic [7:0] e_sum;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(
        input logic st, input logic v, input logic [2:0] op, input logic rt,
        input logic rs, input logic [2:0] aux, input logic last,
        input logic we, input logic [7:0] addr, input logic [7:0] data,
        input logic bsy, input logic dn, input logic rdy, input logic ovf,
        input logic [8:0] cnt, input logic [7:0] sum
    );
        vec_t r;
        r.start = st; r.valid = v; r.op = op; r.rt = rt; r.rs = rs;
        r.aux = aux; r.last = last; r.e_we = we; r.e_addr = addr;
        r.e_data = data; r.e_busy = bsy; r.e_done = dn; r.e_ready = rdy;
        r.e_ovf = ovf; r.e_count = cnt; r.e_sum = sum;
        return r;
    endfunction

    task automatic check1(input string name, input logic [15:0] actual,
                          input logic [15:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start     = v.start;
        in_valid  = v.valid;
        in_opcode = v.op;
        in_rt     = v.rt;
        in_rs     = v.rs;
        in_aux    = v.aux;
        in_last   = v.last;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        check1({tag, ".mem_we"},   16'(mem_we),   16'(v.e_we));
        if (v.e_we) begin
            check1({tag, ".mem_addr"},  16'(mem_addr),  16'(v.e_addr));
            check1({tag, ".mem_wdata"}, 16'(mem_wdata), 16'(v.e_data));
        end
        check1({tag, ".busy"},     16'(busy),     16'(v.e_busy));
        check1({tag, ".done"},     16'(done),     16'(v.e_done));
        check1({tag, ".in_ready"}, 16'(in_ready), 16'(v.e_ready));
        check1({tag, ".overflow"}, 16'(overflow), 16'(v.e_ovf));
        check1({tag, ".count"},    16'(count),    16'(v.e_count));
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        check1({tag, ".checksum"}, 16'(checksum), 16'(v.e_sum));
`endif
    endtask

    // Drive one vector, clock once, then compare away from the edge.
    task automatic step(input string tag, input vec_t v);
        applyStimulus(v);
        @(posedge clk);
        #1;
        checkOutput(tag, v);
    endtask

    vec_t idle_v;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;
        idle_v = mk(0,0,3'd0,0,0,3'd0,0, 0,8'h00,8'h00, 0,0,0,0,9'd0,8'h00);
        applyStimulus(idle_v);

        //        st v  op   rt rs aux  last  we addr   data   bsy dn rdy ovf cnt   sum
        // valid in IDLE is ignored
        vecs[0]  = mk(0,1,3'd5,1,0,3'd6,0,   0,8'h00,8'h00, 0,0,0,0,9'd0,8'h00);
        // single instruction 0xCD
        vecs[1]  = mk(1,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00);
        vecs[2]  = mk(0,1,3'd5,1,0,3'd6,1,   1,8'h00,8'hCD, 0,1,0,0,9'd1,8'hCD);
        vecs[3]  = mk(0,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 0,1,0,0,9'd1,8'hCD);
        // valid in DONE is ignored
        vecs[4]  = mk(0,1,3'd1,0,0,3'd0,0,   0,8'h00,8'h00, 0,1,0,0,9'd1,8'hCD);
        // back-to-back stream of 4, last on the final address
        vecs[5]  = mk(1,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00);
        vecs[6]  = mk(0,1,3'd1,0,0,3'd0,0,   1,8'h00,8'h01, 1,0,1,0,9'd1,8'h01);
        vecs[7]  = mk(0,1,3'd2,1,0,3'd0,0,   1,8'h01,8'h0A, 1,0,1,0,9'd2,8'h0B);
        vecs[8]  = mk(1,1,3'd3,0,1,3'd1,0,   1,8'h02,8'h33, 1,0,1,0,9'd3,8'h38);
        vecs[9]  = mk(0,1,3'd7,1,1,3'd7,1,   1,8'h03,8'hFF, 0,1,0,0,9'd4,8'hC7);
        vecs[10] = mk(0,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 0,1,0,0,9'd4,8'hC7);
        // overflow: 5 tuples without last
        vecs[11] = mk(1,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00);
        vecs[12] = mk(0,1,3'd4,0,0,3'd2,0,   1,8'h00,8'h44, 1,0,1,0,9'd1,8'h44);
        vecs[13] = mk(0,1,3'd0,1,0,3'd5,0,   1,8'h01,8'hA8, 1,0,1,0,9'd2,8'hEC);
        vecs[14] = mk(0,1,3'd6,0,1,3'd0,0,   1,8'h02,8'h16, 1,0,1,0,9'd3,8'hFA);
        vecs[15] = mk(0,1,3'd3,1,1,3'd3,0,   1,8'h03,8'h7B, 0,1,0,1,9'd4,8'h81);
        vecs[16] = mk(0,1,3'd5,0,0,3'd0,0,   0,8'h00,8'h00, 0,1,0,1,9'd4,8'h81);
        vecs[17] = mk(0,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 0,1,0,1,9'd4,8'h81);
        // gapped valid, stray start during LOAD
        vecs[18] = mk(1,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00);
        vecs[19] = mk(0,0,3'd7,1,1,3'd7,1,   0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00);
        vecs[20] = mk(0,1,3'd2,0,0,3'd4,0,   1,8'h00,8'h82, 1,0,1,0,9'd1,8'h82);
        vecs[21] = mk(0,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd1,8'h82);
        vecs[22] = mk(1,0,3'd0,0,0,3'd0,0,   0,8'h00,8'h00, 1,0,1,0,9'd1,8'h82);
        vecs[23] = mk(0,1,3'd1,0,0,3'd0,1,   1,8'h01,8'h01, 0,1,0,0,9'd2,8'h83);

        // Reset values (mem_addr/mem_wdata also checked here)
        repeat (2) @(posedge clk);
        #1;
        check1("reset.mem_addr",  16'(mem_addr),  16'h0000);
        check1("reset.mem_wdata", 16'(mem_wdata), 16'h0000);
        checkOutput("reset", idle_v);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset in the accept cycle of the 2nd tuple cancels its write
        step("rm.start", mk(1,0,3'd0,0,0,3'd0,0, 0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00));
        step("rm.t1",    mk(0,1,3'd5,1,0,3'd6,0, 1,8'h00,8'hCD, 1,0,1,0,9'd1,8'hCD));
        rst = 1'b1;
        step("rm.rst",   mk(0,1,3'd2,0,1,3'd0,0, 0,8'h00,8'h00, 0,0,0,0,9'd0,8'h00));
        check1("rm.rst.mem_addr",  16'(mem_addr),  16'h0000);
        check1("rm.rst.mem_wdata", 16'(mem_wdata), 16'h0000);
        rst = 1'b0;
        step("rm.idle",  idle_v);
        // New session restarts from BASE_ADDR; 0xCD ^ 0x12 = 0xDF
        step("rm.start2", mk(1,0,3'd0,0,0,3'd0,0, 0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00));
        step("rm.t1b",    mk(0,1,3'd5,1,0,3'd6,0, 1,8'h00,8'hCD, 1,0,1,0,9'd1,8'hCD));
        step("rm.t2b",    mk(0,1,3'd2,0,1,3'd0,1, 1,8'h01,8'h12, 0,1,0,0,9'd2,8'hDF));
        step("rm.start3", mk(1,0,3'd0,0,0,3'd0,0, 0,8'h00,8'h00, 1,0,1,0,9'd0,8'h00));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the 8-bit instruction-memory format: accepts decoded instruction fields (opcode, rt, rs, aux) over a valid/ready stream.
- Packs each instruction into one byte and emits sequential byte writes to the instruction memory's write port.
- Sits between the program source (testbench, UART loader or boot ROM) and the 256x8 instruction memory; replaces file-based preload when a program is loaded at run time.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable bytes; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, first address written after each start.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session.
- in_valid  input  1  field tuple present.
- in_ready  output  1  loader can accept a tuple this cycle.
- in_opcode  input  3  instruction opcode field.
- in_rt  input  1  rt register-select bit.
- in_rs  input  1  rs register-select bit.
- in_aux  input  3  aux field.
- in_last  input  1  marks the final instruction of the program.
- mem_we  output  1  write strobe to the instruction memory.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  8  packed instruction byte.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE.
- overflow  output  1  session ended because memory filled before in_last.
- count  output  ADDR_W+1  instructions written in the current or last session.

Behaviour:
- Encoding: mem_wdata = {aux[2:0], rs, rt, opcode[2:0]}, i.e. bits 7:5 aux, bit 4 rs, bit 3 rt, bits 2:0 opcode.
- Reset values: state IDLE; write pointer = BASE_ADDR; mem_we, mem_addr, mem_wdata, count, overflow, busy, done, in_ready = 0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - in_ready = 0.
  - start → LOAD; pointer = BASE_ADDR; count = 0; overflow = 0.
- LOAD:
  - in_ready = 1.
  - Handshake fires on in_valid & in_ready.
  - The following cycle: mem_we = 1, mem_addr = pointer at accept, mem_wdata = packed byte. Latency is exactly 1 cycle.
  - Pointer and count increment on the accept cycle.
  - mem_we is a single-cycle strobe per accepted tuple; back-to-back accepts produce back-to-back writes.
  - Accept with in_last = 1 → DONE.
  - Accept that writes address BASE_ADDR+DEPTH-1 without in_last → DONE with overflow = 1.
  - in_last together with the final address → DONE with overflow = 0.
  - in_ready drops to 0 in the cycle after the terminating accept (registered).
  - start during LOAD is ignored.
- DONE:
  - in_ready = 0; done = 1; count and overflow hold.
  - start → LOAD, with the same re-initialisation as from IDLE.
- The last write strobe occurs in the first DONE cycle.
- in_valid while in_ready = 0 is ignored; no data is captured.
- Pointer arithmetic is modulo 2**ADDR_W. With BASE_ADDR + DEPTH ≤ 2**ADDR_W, no wrap occurs within a session.
- Reset mid-session:
  - Aborts immediately to IDLE; a pending write strobe is cancelled.
  - Memory already written is not cleared.

Optional Feature:
- Macro: INSTR_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[7:0]: running XOR of every written byte.
  - Cleared on start and on rst; updated in the same cycle as mem_we; held in DONE.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package instr_pkg holds:
  - field widths and bit positions (OPCODE_LSB=0, RT_BIT=3, RS_BIT=4, AUX_LSB=5);
  - INSTR_W=8;
  - loader state enum (IDLE/LOAD/DONE);
  - pack function for fields → byte.
- The decoder side uses the same constants.
- One natural sub-module: instr_packer, purely combinational field → byte, reusable by testbench models.
- FSM, pointer and write register stay in the top module.

Test Plan:
- Single instruction: start, then one tuple opcode=101, rt=1, rs=0, aux=110, last=1 → next cycle mem_we=1, addr=0x00, wdata=0xCD; then done=1, count=1, overflow=0.
- Back-to-back stream: 4 tuples on consecutive cycles, in_valid held high, last on the 4th → mem_we high for 4 consecutive cycles at addresses 0..3; count=4.
- Overflow: DEPTH=4, 5 tuples without last → writes at addresses 0..3 only; overflow=1; in_ready=0; the 5th tuple is not accepted.
- Gapped valid plus stray inputs: in_valid in IDLE produces no writes; start pulsed during LOAD leaves pointer and count unchanged.
- Reset mid-session: rst asserted in the accept cycle of the 2nd tuple → no write strobe follows; all outputs at reset values; a new start writes from BASE_ADDR.
- Checksum (macro defined): bytes 0xCD, 0x12 written → checksum=0xDF; a new start clears it to 0x00.
